// File: rtl/mem_sched_pkg.sv
// Shared state encoding and default geometry for the RAM port scheduler.
package mem_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RD_CAPTURE
    } sched_state_t;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    localparam logic [DATA_W_DEF-1:0] CLR_DATA = '0;

endpackage

// File: rtl/tick_gen.sv
// Free-running 0..TICK_DIV-1 counter; tick is a one-cycle enable at the wrap, not a clock.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_scheduler.sv
// Owns the single RAM port and arbitrates clear > write > scan, one access per cycle.
//
// state      | meaning
// IDLE       | arbitrate pending clear, armed write, pending scan tick
// CLEAR      | zero-fill one address per cycle, ascending
// WRITE      | single-cycle switch write, wr_ack and show update
// RD_ISSUE   | scan address presented to RAM
// RD_WAIT    | waiting out RAM read latency
// RD_CAPTURE | read data shown, scan address advanced
module ram_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TICK_DIV = 50000000,
    parameter int RD_LAT   = 2
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    input  logic              scan_en,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] show_addr,
    output logic [DATA_W-1:0] show_data,
    output logic              show_valid
);

    localparam int WAIT_INIT = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
    localparam int WAIT_W    = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    sched_state_t      state;
    logic [ADDR_W-1:0] scan_addr;
    logic [WAIT_W-1:0] wait_cnt;
    logic              tick;
    logic              tick_pending;
    logic              clr_pend;
    logic              wr_arm;
    logic              wr_ready;
    logic              rd_done;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .tick     (tick)
    );

    // With RD_LAT of 1 the data is already due on the edge leaving RD_ISSUE.
    assign rd_done = (state == RD_ISSUE) ? (RD_LAT == 1) : (wait_cnt == '0);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            scan_addr    <= '0;
            wait_cnt     <= '0;
            tick_pending <= 1'b0;
            clr_pend     <= 1'b0;
            wr_arm       <= 1'b0;
            wr_ready     <= 1'b1;
            wr_ack       <= 1'b0;
            busy         <= 1'b0;
            ram_addr     <= '0;
            ram_data     <= '0;
            ram_wren     <= 1'b0;
            show_addr    <= '0;
            show_data    <= '0;
            show_valid   <= 1'b0;
        end else begin
            wr_ack     <= 1'b0;
            show_valid <= 1'b0;
            ram_wren   <= 1'b0;
            ram_data   <= '0;

            // One write per rising request: re-arm only after wr_req has been seen low.
            if (!wr_req) begin
                wr_ready <= 1'b1;
            end else if (wr_ready && !wr_arm) begin
                wr_arm <= 1'b1;
            end
            if (tick) begin
                tick_pending <= 1'b1;
            end
            if (clr_start && state != CLEAR) begin
                clr_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clr_pend) begin
                        state    <= CLEAR;
                        clr_pend <= 1'b0;
                        busy     <= 1'b1;
                        ram_wren <= 1'b1;
                        ram_addr <= '0;
                        ram_data <= DATA_W'(CLR_DATA);
                    end else if (wr_arm) begin
                        state      <= WRITE;
                        wr_arm     <= 1'b0;
                        wr_ready   <= 1'b0;
                        wr_ack     <= 1'b1;
                        ram_wren   <= 1'b1;
                        ram_addr   <= wr_addr;
                        ram_data   <= wr_data;
                        show_addr  <= wr_addr;
                        show_data  <= wr_data;
                        show_valid <= 1'b1;
                    end else if (tick_pending && scan_en) begin
                        state        <= RD_ISSUE;
                        tick_pending <= 1'b0;
                        ram_addr     <= scan_addr;
                    end
                end
                CLEAR: begin
                    if (ram_addr == '1) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        scan_addr    <= '0;
                        tick_pending <= 1'b0;
                        show_addr    <= '0;
                        show_data    <= '0;
                        show_valid   <= 1'b1;
                    end else begin
                        ram_wren <= 1'b1;
                        ram_addr <= ram_addr + 1'b1;
                        ram_data <= DATA_W'(CLR_DATA);
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                RD_ISSUE, RD_WAIT: begin
                    if (rd_done) begin
                        state      <= RD_CAPTURE;
                        show_addr  <= scan_addr;
                        show_data  <= ram_q;
                        show_valid <= 1'b1;
                        scan_addr  <= scan_addr + 1'b1;
                    end else if (state == RD_ISSUE) begin
                        state    <= RD_WAIT;
                        wait_cnt <= WAIT_W'(WAIT_INIT);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RD_CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_scheduler.sv
// Directed bench for ram_port_scheduler with a behavioural 32x8 RAM (one registered read stage).
module tb_ram_port_scheduler;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic       wr_req;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       clr_start;
    logic       scan_en;
    logic       busy;
    logic [4:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic [7:0] ram_q;
    logic [4:0] show_addr;
    logic [7:0] show_data;
    logic       show_valid;

    logic [7:0] mem [0:31];
    logic [7:0] q_reg;
    logic       ram_init;

    int n_chk  = 0;
    int n_fail = 0;

    ram_port_scheduler #(
        .ADDR_W   (5),
        .DATA_W   (8),
        .TICK_DIV (8),
        .RD_LAT   (2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .clr_start  (clr_start),
        .scan_en    (scan_en),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q),
        .show_addr  (show_addr),
        .show_data  (show_data),
        .show_valid (show_valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (ram_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(32'h40 + i);
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end
        q_reg <= mem[ram_addr];
    end
    assign ram_q = q_reg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {2'b00, wr_ack, busy, ram_addr, ram_data, ram_wren,
                show_addr, show_data, show_valid};
    endfunction

    // Waits (bounded) for show_valid, checks the shown pair, then checks the pulse is one cycle.
    task automatic wait_show(input string tag, input logic [4:0] ea, input logic [7:0] ed,
                             output int n);
        n = 0;
        while (!show_valid && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk({tag, "_seen"}, 32'(show_valid), 32'd1);
        chk({tag, "_pair"}, {19'd0, show_addr, show_data}, {19'd0, ea, ed});
        @(negedge CLOCK_50);
        chk({tag, "_pulse"}, 32'(show_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks, wrens, first_ack, shows, bad, first_busy, busy_cnt;
        int vcnt, vidx, vidx2, exp_a, nz;
        logic [4:0] wa, sa, sa2;
        logic [7:0] wd, sd, sd2;
        logic [5:0] iss;

        RESET_N = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clr_start = 1'b0; scan_en = 1'b0; ram_init = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_outputs", out_vec(), 32'd0);

        // Periodic scan of the preloaded pattern, including the 31 -> 0 wrap.
        ram_init = 1'b0;
        scan_en  = 1'b1;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        for (int i = 0; i < 33; i++) begin
            wait_show("scan", 5'(i), 8'(32'h40 + (i % 32)), n);
            if (i > 0) chk("scan_period", 32'(n + 1), 32'd8);
        end
        scan_en = 1'b0;

        // Held write request produces exactly one write.
        wr_addr = 5'h05; wr_data = 8'hA7; wr_req = 1'b1;
        acks = 0; wrens = 0; first_ack = 0; shows = 0;
        wa = '0; wd = '0; sa = '0; sd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLOCK_50);
            if (wr_ack) begin acks++; if (first_ack == 0) first_ack = i; end
            if (ram_wren) begin wrens++; wa = ram_addr; wd = ram_data; end
            if (show_valid) begin shows++; sa = show_addr; sd = show_data; end
        end
        wr_req = 1'b0;
        chk("wr_ack_count", 32'(acks), 32'd1);
        chk("wr_wren_count", 32'(wrens), 32'd1);
        chk("wr_latency", 32'(first_ack), 32'd2);
        chk("wr_ram_pair", {19'd0, wa, wd}, {19'd0, 5'h05, 8'hA7});
        chk("wr_show_count", 32'(shows), 32'd1);
        chk("wr_show_pair", {19'd0, sa, sd}, {19'd0, 5'h05, 8'hA7});
        @(negedge CLOCK_50);
        scan_en = 1'b1;
        for (int i = 1; i <= 4; i++) wait_show("scan_pre5", 5'(i), 8'(32'h40 + i), n);
        wait_show("scan_addr5", 5'h05, 8'hA7, n);
        scan_en = 1'b0;

        // Full clear.
        clr_start = 1'b1;
        busy_cnt = 0; first_busy = 0; wrens = 0; bad = 0; exp_a = 0;
        vcnt = 0; vidx = 0; sa = '1; sd = '1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLOCK_50);
            if (i == 1) clr_start = 1'b0;
            if (busy) begin busy_cnt++; if (first_busy == 0) first_busy = i; end
            if (ram_wren) begin
                if (ram_addr !== 5'(exp_a) || ram_data !== 8'h00) bad++;
                exp_a++;
                wrens++;
            end
            if (show_valid) begin vcnt++; vidx = i; sa = show_addr; sd = show_data; end
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("clr_busy_start", 32'(first_busy), 32'd2);
        chk("clr_wren_count", 32'(wrens), 32'd32);
        chk("clr_addr_data_errs", 32'(bad), 32'd0);
        chk("clr_show_count", 32'(vcnt), 32'd1);
        chk("clr_show_when", 32'(vidx), 32'd34);
        chk("clr_show_pair", {19'd0, sa, sd}, 32'd0);
        nz = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== 8'h00) nz++;
        chk("clr_ram_nonzero", 32'(nz), 32'd0);
        scan_en = 1'b1;
        for (int i = 0; i < 5; i++) wait_show("scan_cleared", 5'(i), 8'h00, n);

        // clr_start while the next read sits in RD_WAIT.
        repeat (6) @(negedge CLOCK_50);
        clr_start = 1'b1;
        @(negedge CLOCK_50);
        clr_start = 1'b0;
        chk("rdwait_clr_show", {18'd0, show_valid, show_addr, show_data}, {18'd0, 1'b1, 5'h05, 8'h00});
        busy_cnt = 0; first_busy = 0; vcnt = 0; vidx = 0;
        for (int i = 2; i <= 40; i++) begin
            @(negedge CLOCK_50);
            if (busy) begin busy_cnt++; if (first_busy == 0) first_busy = i; end
            if (show_valid) begin vcnt++; vidx = i; end
        end
        chk("rdwait_clr_start", 32'(first_busy), 32'd3);
        chk("rdwait_clr_busy", 32'(busy_cnt), 32'd32);
        chk("rdwait_clr_shows", 32'(vcnt), 32'd1);
        chk("rdwait_clr_exit", 32'(vidx), 32'd35);
        wait_show("scan_after_clr", 5'h00, 8'h00, n);

        // Write request rising in the same cycle as a scan tick.
        repeat (3) @(negedge CLOCK_50);
        wr_addr = 5'h0A; wr_data = 8'h5C; wr_req = 1'b1;
        first_ack = 0; wa = '0; wd = '0; vcnt = 0; vidx = 0; vidx2 = 0;
        sa = '0; sd = '0; sa2 = '0; sd2 = '0; iss = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            if (wr_ack && first_ack == 0) first_ack = i;
            if (ram_wren) begin wa = ram_addr; wd = ram_data; end
            if (i == 4) iss = {ram_wren, ram_addr};
            if (show_valid) begin
                vcnt++;
                if (vcnt == 1) begin vidx = i; sa = show_addr; sd = show_data; end
                else begin vidx2 = i; sa2 = show_addr; sd2 = show_data; end
            end
        end
        wr_req = 1'b0;
        scan_en = 1'b0;
        chk("tie_wr_latency", 32'(first_ack), 32'd2);
        chk("tie_wr_pair", {19'd0, wa, wd}, {19'd0, 5'h0A, 8'h5C});
        chk("tie_read_issue", 32'(iss), {26'd0, 1'b0, 5'h01});
        chk("tie_show_count", 32'(vcnt), 32'd2);
        chk("tie_show_times", {16'(vidx), 16'(vidx2)}, {16'd2, 16'd6});
        chk("tie_show_wr", {19'd0, sa, sd}, {19'd0, 5'h0A, 8'h5C});
        chk("tie_show_rd", {19'd0, sa2, sd2}, {19'd0, 5'h01, 8'h00});

        // Ticks while one is already pending are dropped, not queued.
        repeat (28) @(negedge CLOCK_50);
        scan_en = 1'b1;
        vcnt = 0; vidx = 0; sa = '1; sd = '1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge CLOCK_50);
            if (show_valid) begin vcnt++; vidx = j; sa = show_addr; sd = show_data; end
        end
        chk("drop_show_count", 32'(vcnt), 32'd1);
        chk("drop_show_when", 32'(vidx), 32'd3);
        chk("drop_show_pair", {19'd0, sa, sd}, {19'd0, 5'h02, 8'h00});
        @(negedge CLOCK_50);
        chk("drop_next_read", {18'd0, show_valid, show_addr, show_data}, {18'd0, 1'b1, 5'h03, 8'h00});
        scan_en = 1'b0;

        // Reset in the middle of a clear, just before address 10 is written.
        @(negedge CLOCK_50);
        clr_start = 1'b1;
        @(negedge CLOCK_50);
        clr_start = 1'b0;
        repeat (11) @(negedge CLOCK_50);
        chk("midclr_at_addr10", {25'd0, busy, ram_wren, ram_addr}, {25'd0, 1'b1, 1'b1, 5'h0A});
        RESET_N = 1'b0;
        #1;
        chk("midclr_async_reset", out_vec(), 32'd0);
        wrens = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            if (ram_wren || busy) wrens++;
        end
        chk("midclr_quiet_in_reset", 32'(wrens), 32'd0);
        chk("midclr_addr10_kept", 32'(mem[10]), 32'h5C);
        RESET_N = 1'b1;
        wrens = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLOCK_50);
            if (ram_wren || busy) wrens++;
        end
        chk("post_reset_idle", 32'(wrens), 32'd0);
        scan_en = 1'b1;
        wait_show("post_reset_scan", 5'h00, 8'h00, n);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
